dout_wr_scheduler: RTL and testbench

Write-back scheduler for the output data memory: arbitrates result words from several vector lanes onto the memory's single write port (`we`/`address`/`wd`). It counts accepted writes against a programmed frame size and, when the frame is complete, toggles `startIO` so the memory dumps its contents to file. It sits between the vector execution lanes and the output memory. It is the only driver of that memory's write port.

---
 rtl/dout_wr_scheduler.sv | 145 ++++++++++++++
 tb/tb_dout_wr_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dout_wr_scheduler.sv
// Round-robin write-back scheduler: funnels lane results onto the output memory write port
// and toggles startIO when a frame completes. Optional bounds checking: DOUT_BOUNDS_CHECK_EN.
module dout_wr_scheduler #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned LANES = 4,
  parameter int unsigned BASE  = 24,
  parameter int unsigned DEPTH = 10000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       total_words,
  input  logic [LANES-1:0]       lane_valid,
  input  logic [LANES*WIDTH-1:0] lane_addr,
  input  logic [LANES*WIDTH-1:0] lane_wd,
  output logic [LANES-1:0]       lane_ready,
  output logic                   mem_we,
  output logic [WIDTH-1:0]       mem_address,
  output logic [WIDTH-1:0]       mem_wd,
  output logic                   startIO,
  output logic                   busy,
  output logic                   done,
  output logic                   err_oob
);

  localparam int unsigned PW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DUMP = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] target;
  logic             hold;

  logic [PW-1:0]    idx;
  logic [PW-1:0]    gidx;
  logic             found;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wd;
  logic             in_range;
  logic [WIDTH-1:0] count_nx;

`ifdef DOUT_BOUNDS_CHECK_EN
  localparam logic [WIDTH-1:0] LOW   = WIDTH'(BASE);
  localparam logic [WIDTH:0]   LIMIT = (WIDTH+1)'(BASE + DEPTH);
`endif

  // First requesting lane at or after the pointer, wrapping around.
  always_comb begin
    found      = 1'b0;
    gidx       = '0;
    idx        = '0;
    lane_ready = '0;
    if (state == RUN) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        idx = PW'((32'(ptr) + i) % LANES);
        if (!found && lane_valid[idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
    end
    if (found) lane_ready[gidx] = 1'b1;
    sel_addr = lane_addr[32'(gidx)*WIDTH +: WIDTH];
    sel_wd   = lane_wd[32'(gidx)*WIDTH +: WIDTH];
`ifdef DOUT_BOUNDS_CHECK_EN
    in_range = (sel_addr >= LOW) && ({1'b0, sel_addr} < LIMIT);
`else
    in_range = 1'b1;
`endif
    count_nx = count + WIDTH'(1);
  end

  assign busy = (state == RUN) || (state == DUMP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      count       <= '0;
      target      <= '0;
      hold        <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_wd      <= '0;
      startIO     <= 1'b0;
      done        <= 1'b0;
`ifdef DOUT_BOUNDS_CHECK_EN
      err_oob     <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target <= total_words;
            count  <= '0;
`ifdef DOUT_BOUNDS_CHECK_EN
            err_oob <= 1'b0;
`endif
            state  <= (total_words == '0) ? DUMP : RUN;
          end
        end
        RUN: begin
          if (found) begin
            ptr <= (gidx == PW'(LANES - 1)) ? '0 : gidx + PW'(1);
            if (in_range) begin
              mem_we      <= 1'b1;
              mem_address <= sel_addr;
              mem_wd      <= sel_wd;
              count       <= count_nx;
              if (count_nx == target) state <= DUMP;
            end
`ifdef DOUT_BOUNDS_CHECK_EN
            else begin
              err_oob <= 1'b1;
            end
`endif
          end
        end
        DUMP: begin
          // First DUMP cycle only waits so the last write lands before the dump trigger.
          if (!hold) begin
            hold <= 1'b1;
          end else begin
            hold    <= 1'b0;
            startIO <= ~startIO;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DOUT_BOUNDS_CHECK_EN
  assign err_oob = 1'b0;
`endif

endmodule

// File: tb/tb_dout_wr_scheduler.sv
// Directed table-driven bench for dout_wr_scheduler, plus hand sequences for bounds and reset.
module tb_dout_wr_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [23:0]  total_words;
  logic [3:0]   lane_valid;
  logic [95:0]  lane_addr;
  logic [95:0]  lane_wd;
  logic [3:0]   lane_ready;
  logic         mem_we;
  logic [23:0]  mem_address;
  logic [23:0]  mem_wd;
  logic         startIO;
  logic         busy;
  logic         done;
  logic         err_oob;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dout_wr_scheduler #(.WIDTH(24), .LANES(4), .BASE(24), .DEPTH(10000)) dut (
    .clk(clk), .rst(rst), .start(start), .total_words(total_words),
    .lane_valid(lane_valid), .lane_addr(lane_addr), .lane_wd(lane_wd),
    .lane_ready(lane_ready), .mem_we(mem_we), .mem_address(mem_address),
    .mem_wd(mem_wd), .startIO(startIO), .busy(busy), .done(done), .err_oob(err_oob)
  );

  typedef struct {
    logic        r;
    logic        s;
    logic [23:0] tw;
    logic [3:0]  v;
    logic [23:0] a;
    logic [23:0] d;
    logic [3:0]  er;
    logic        ew;
    logic [23:0] ea;
    logic [23:0] ed;
    logic        es;
    logic        eb;
    logic        edn;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(int unsigned r, int unsigned s, int unsigned tw, int unsigned v,
                              int unsigned a, int unsigned d, int unsigned er, int unsigned ew,
                              int unsigned ea, int unsigned ed, int unsigned es, int unsigned eb,
                              int unsigned edn);
    vec_t x;
    x.r = 1'(r);  x.s = 1'(s);  x.tw = 24'(tw); x.v = 4'(v);
    x.a = 24'(a); x.d = 24'(d); x.er = 4'(er);  x.ew = 1'(ew);
    x.ea = 24'(ea); x.ed = 24'(ed); x.es = 1'(es); x.eb = 1'(eb); x.edn = 1'(edn);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Lane i carries address a+i and data d+i.
  task automatic drive(input logic r, input logic s, input logic [23:0] tw, input logic [3:0] v,
                       input logic [23:0] a, input logic [23:0] d);
    rst = r; start = s; total_words = tw; lane_valid = v;
    for (int i = 0; i < 4; i++) begin
      lane_addr[i*24 +: 24] = a + 24'(i);
      lane_wd[i*24 +: 24]   = d + 24'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [23:0] ba[4];
  logic        xw, xr, xd;

  initial begin
    // reset preamble, fairness, single lane, zero frame + back-to-back
    tbl[0]  = mk(1,0,0,4'hF,0,0,      0,0,0,0,      0,0,0);
    tbl[1]  = mk(1,0,0,4'hF,0,0,      0,0,0,0,      0,0,0);
    tbl[2]  = mk(0,1,8,0,0,0,         0,0,0,0,      0,1,0);
    for (int k = 0; k < 8; k++)
      tbl[3+k] = mk(0,0,0,4'hF,100,'h500, 1 << (k % 4),1,100 + k % 4,'h500 + k % 4, 0,1,0);
    tbl[11] = mk(0,0,0,4'hF,100,'h500, 0,0,0,0,     0,1,0);
    tbl[12] = mk(0,0,0,0,0,0,         0,0,0,0,      1,0,1);
    tbl[13] = mk(0,1,3,0,0,0,         0,0,0,0,      1,1,0);
    tbl[14] = mk(0,0,0,4,22,8,        4,1,24,'hA,   1,1,0);
    tbl[15] = mk(0,0,0,4,23,9,        4,1,25,'hB,   1,1,0);
    tbl[16] = mk(0,0,0,4,24,10,       4,1,26,'hC,   1,1,0);
    tbl[17] = mk(0,0,0,4,24,10,       0,0,0,0,      1,1,0);
    tbl[18] = mk(0,0,0,0,0,0,         0,0,0,0,      0,0,1);
    tbl[19] = mk(0,1,0,0,0,0,         0,0,0,0,      0,1,0);
    tbl[20] = mk(0,0,0,0,0,0,         0,0,0,0,      0,1,0);
    tbl[21] = mk(0,0,0,0,0,0,         0,0,0,0,      1,0,1);
    tbl[22] = mk(0,1,1,0,0,0,         0,0,0,0,      1,1,0);
    tbl[23] = mk(0,0,0,1,200,'h77,    1,1,200,'h77, 1,1,0);
    tbl[24] = mk(0,1,5,0,0,0,         0,0,0,0,      1,1,0);
    tbl[25] = mk(0,0,0,0,0,0,         0,0,0,0,      0,0,1);
    tbl[26] = mk(0,0,0,0,0,0,         0,0,0,0,      0,0,0);

    drive(1, 0, 0, 4'hF, 0, 0);
    tick();

    for (int k = 0; k < 27; k++) begin
      drive(tbl[k].r, tbl[k].s, tbl[k].tw, tbl[k].v, tbl[k].a, tbl[k].d);
      #1;
      chk($sformatf("r%0d_ready", k), 32'(lane_ready), 32'(tbl[k].er));
      tick();
      chk($sformatf("r%0d_we", k), 32'(mem_we), 32'(tbl[k].ew));
      if (tbl[k].ew) begin
        chk($sformatf("r%0d_addr", k), 32'(mem_address), 32'(tbl[k].ea));
        chk($sformatf("r%0d_wd", k), 32'(mem_wd), 32'(tbl[k].ed));
      end
      chk($sformatf("r%0d_startIO", k), 32'(startIO), 32'(tbl[k].es));
      chk($sformatf("r%0d_busy", k), 32'(busy), 32'(tbl[k].eb));
      chk($sformatf("r%0d_done", k), 32'(done), 32'(tbl[k].edn));
      if (k == 1) begin
        chk("rst_addr", 32'(mem_address), 32'h0);
        chk("rst_wd", 32'(mem_wd), 32'h0);
        chk("rst_oob", 32'(err_oob), 32'h0);
      end
    end

    // bounds: lane 0 writes 23, 24, 10024, 10023 with total_words=2
    ba[0] = 24'd23; ba[1] = 24'd24; ba[2] = 24'd10024; ba[3] = 24'd10023;
    drive(0, 1, 2, 0, 0, 0);
    tick();
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 0, 4'h1, ba[j], 24'(16 + j));
`ifdef DOUT_BOUNDS_CHECK_EN
      xr = 1'b1; xw = (j == 1) || (j == 3); xd = 1'b0;
`else
      xr = (j < 2); xw = (j < 2); xd = (j == 3);
`endif
      #1;
      chk($sformatf("oob%0d_ready", j), 32'(lane_ready), xr ? 32'h1 : 32'h0);
      tick();
      chk($sformatf("oob%0d_we", j), 32'(mem_we), 32'(xw));
      if (xw) chk($sformatf("oob%0d_addr", j), 32'(mem_address), 32'(ba[j]));
      chk($sformatf("oob%0d_done", j), 32'(done), 32'(xd));
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int e = 0; e < 2; e++) begin
      tick();
`ifdef DOUT_BOUNDS_CHECK_EN
      chk($sformatf("oob_tail%0d_done", e), 32'(done), (e == 1) ? 32'h1 : 32'h0);
`else
      chk($sformatf("oob_tail%0d_done", e), 32'(done), 32'h0);
`endif
    end
    chk("oob_startIO", 32'(startIO), 32'h1);
`ifdef DOUT_BOUNDS_CHECK_EN
    chk("oob_flag", 32'(err_oob), 32'h1);
`else
    chk("oob_flag", 32'(err_oob), 32'h0);
`endif

    // reset after 2 of 5 writes, then a 1-word frame
    drive(0, 1, 5, 0, 0, 0);
    tick();
    chk("mid_oob_clr", 32'(err_oob), 32'h0);
    chk("mid_busy", 32'(busy), 32'h1);
    for (int j = 0; j < 2; j++) begin
      drive(0, 0, 0, 4'h1, 24'(300 + j), 24'(j));
      tick();
      chk($sformatf("mid%0d_we", j), 32'(mem_we), 32'h1);
      chk($sformatf("mid%0d_addr", j), 32'(mem_address), 32'(300 + j));
    end
    drive(1, 0, 0, 4'h1, 302, 2);
    tick();
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_we", 32'(mem_we), 32'h0);
    chk("mid_rst_startIO", 32'(startIO), 32'h0);
    drive(0, 0, 0, 4'h1, 302, 2);
    #1;
    chk("mid_idle_ready", 32'(lane_ready), 32'h0);
    tick();
    drive(0, 1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 4'h8, 397, 'h30);
    #1;
    chk("new_ready", 32'(lane_ready), 32'h8);
    tick();
    chk("new_we", 32'(mem_we), 32'h1);
    chk("new_addr", 32'(mem_address), 32'd400);
    chk("new_wd", 32'(mem_wd), 32'h33);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("new_hold_done", 32'(done), 32'h0);
    tick();
    chk("new_done", 32'(done), 32'h1);
    chk("new_startIO", 32'(startIO), 32'h1);
    chk("new_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
